// File: rtl/apb_uart_if.sv
// APB3 request/response bundle for apb_uart.
// The master drives the request fields; the slave returns read data, ready and error.
interface apb_uart_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart.sv
// APB3 slave UART: one TX holding buffer, one RX buffer, optional parity and a
// 16x oversampling baud tick. Two instances share a bus, selected by byte-address bit 5.
module apb_uart #(
  parameter logic ADDR_SEL = 1'b0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PCLKG,
  input  logic       clk_16m,
  input  logic       clk_16m_rstn,
  apb_uart_if.slave  apb,
  input  logic [3:0] ECOREVNUM,
  input  logic       RXD,
  output logic       TXD,
  output logic       TXEN,
  output logic       BAUDTICK,
  output logic       TXINT,
  output logic       RXINT,
  output logic       TXOVRINT,
  output logic       RXOVRINT,
  output logic       UARTINT_FLAG,
  output logic       UARTINT
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_state_e;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_INT    = 3'd3;
  localparam logic [2:0] OFF_BAUD   = 3'd4;
  localparam logic [2:0] OFF_PAR    = 3'd5;

  // PADDR carries word address bits [11:2], so byte bit 5 is PADDR[3].
  logic       hit, wr_en, rd_en;
  logic [2:0] off;
  assign hit   = apb.PSEL & (apb.PADDR[3] == ADDR_SEL);
  assign off   = apb.PADDR[2:0];
  assign wr_en = hit & apb.PENABLE & apb.PWRITE;
  assign rd_en = hit & apb.PENABLE & ~apb.PWRITE;

  logic unused_ok;
  assign unused_ok = &{1'b0, PCLKG, clk_16m, clk_16m_rstn, apb.PADDR[9:4], apb.PWDATA[31:19]};

  logic [6:0]  ctrl_q, ctrl_d;
  logic [4:0]  int_q, int_d;
  logic [18:0] baud_div_q, baud_div_d;
  logic [1:0]  par_q, par_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        tx_full_q, tx_full_d;
  logic        rx_full_q, rx_full_d;
  logic        tx_ovr_q, tx_ovr_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        par_err_q, par_err_d;

  logic [14:0] baud_cnt_q;
  logic        tick_q;

  uart_state_e tx_state_q;
  logic [3:0]  tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_shift_q;
  logic        tx_par_q;
  logic        txd_q, txen_q;

  uart_state_e rx_state_q;
  logic [3:0]  rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;

  logic tx_load, tx_wr, tx_ovr_evt;
  logic rx_mid, rx_done, rx_rd, rx_store, rx_ovr_evt, rx_par_exp, par_evt;

  assign tx_load    = tick_q & (tx_state_q == S_IDLE) & ctrl_q[0] & tx_full_q;
  assign tx_wr      = wr_en & (off == OFF_DATA);
  assign tx_ovr_evt = tx_wr & tx_full_q & ~tx_load;

  assign rx_mid     = tick_q & (rx_cnt_q == 4'd15);
  assign rx_done    = rx_mid & (rx_state_q == S_STOP);
  assign rx_rd      = rd_en & (off == OFF_DATA);
  assign rx_ovr_evt = rx_done & rx_full_q & ~rx_rd;
  assign rx_store   = rx_done & ~rx_ovr_evt;
  assign rx_par_exp = par_q[1] ? ~^rx_shift_q : ^rx_shift_q;
  assign par_evt    = rx_mid & (rx_state_q == S_PAR) & (rxd_s2_q != rx_par_exp);

  // Register file next state: software clears are applied first so hardware sets win.
  always_comb begin
    ctrl_d     = ctrl_q;
    int_d      = int_q;
    baud_div_d = baud_div_q;
    par_d      = par_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    tx_full_d  = tx_full_q;
    rx_full_d  = rx_full_q;
    tx_ovr_d   = tx_ovr_q;
    rx_ovr_d   = rx_ovr_q;
    par_err_d  = par_err_q;
    if (wr_en) begin
      case (off)
        OFF_STATUS: begin
          tx_ovr_d  = tx_ovr_q  & ~apb.PWDATA[2];
          rx_ovr_d  = rx_ovr_q  & ~apb.PWDATA[3];
          par_err_d = par_err_q & ~apb.PWDATA[4];
        end
        OFF_CTRL: ctrl_d     = apb.PWDATA[6:0];
        OFF_INT:  int_d      = int_q & ~apb.PWDATA[4:0];
        OFF_BAUD: baud_div_d = apb.PWDATA[18:0];
        OFF_PAR:  par_d      = apb.PWDATA[1:0];
        default:  ;
      endcase
    end
    if (tx_load) tx_full_d = 1'b0;
    if (tx_wr && !tx_ovr_evt) begin
      tx_buf_d  = apb.PWDATA[7:0];
      tx_full_d = 1'b1;
    end
    if (rx_rd) rx_full_d = 1'b0;
    if (rx_store) begin
      rx_buf_d  = rx_shift_q;
      rx_full_d = 1'b1;
    end
    if (tx_ovr_evt) tx_ovr_d = 1'b1;
    if (rx_ovr_evt) rx_ovr_d = 1'b1;
    if (par_evt)    par_err_d = 1'b1;
    int_d[0] = int_d[0] | (tx_load & ctrl_q[2]);
    int_d[1] = int_d[1] | (rx_store & ctrl_q[3]);
    int_d[2] = int_d[2] | (tx_ovr_evt & ctrl_q[4]);
    int_d[3] = int_d[3] | (rx_ovr_evt & ctrl_q[5]);
    int_d[4] = int_d[4] | par_evt;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= '0;
      int_q      <= '0;
      baud_div_q <= '0;
      par_q      <= '0;
      tx_buf_q   <= '0;
      rx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_full_q  <= 1'b0;
      tx_ovr_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      int_q      <= int_d;
      baud_div_q <= baud_div_d;
      par_q      <= par_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_full_q  <= rx_full_d;
      tx_ovr_q   <= tx_ovr_d;
      rx_ovr_q   <= rx_ovr_d;
      par_err_q  <= par_err_d;
    end
  end

  // Baud tick: one pulse every BAUDDIV[18:4] cycles; a zero divisor stops it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (baud_div_q[18:4] == 15'd0) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (baud_cnt_q <= 15'd1) begin
      baud_cnt_q <= baud_div_q[18:4];
      tick_q     <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_q - 15'd1;
      tick_q     <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      txen_q     <= 1'b0;
    end else if (tick_q) begin
      if (tx_state_q == S_IDLE) begin
        if (tx_load) begin
          tx_shift_q <= tx_buf_q;
          tx_par_q   <= par_q[1] ? ~^tx_buf_q : ^tx_buf_q;
          tx_cnt_q   <= 4'd0;
          txd_q      <= 1'b0;
          txen_q     <= 1'b1;
          tx_state_q <= S_START;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd15) begin
          case (tx_state_q)
            S_START: begin
              txd_q      <= tx_shift_q[0];
              tx_idx_q   <= 3'd0;
              tx_state_q <= S_DATA;
            end
            S_DATA: begin
              if (tx_idx_q == 3'd7) begin
                if (par_q[0]) begin
                  txd_q      <= tx_par_q;
                  tx_state_q <= S_PAR;
                end else begin
                  txd_q      <= 1'b1;
                  tx_state_q <= S_STOP;
                end
              end else begin
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                txd_q      <= tx_shift_q[1];
                tx_idx_q   <= tx_idx_q + 3'd1;
              end
            end
            S_PAR: begin
              txd_q      <= 1'b1;
              tx_state_q <= S_STOP;
            end
            default: begin
              txd_q      <= 1'b1;
              txen_q     <= 1'b0;
              tx_state_q <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Start bit is rechecked 8 ticks after the edge, then the counter is rebased so
  // every later sample lands at a bit centre.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      if (rx_state_q == S_IDLE) begin
        if (ctrl_q[1] && rxd_prev_q && !rxd_s2_q) begin
          rx_cnt_q   <= 4'd0;
          rx_state_q <= S_START;
        end
      end else if (tick_q) begin
        rx_cnt_q <= rx_cnt_q + 4'd1;
        case (rx_state_q)
          S_START: begin
            if (rx_cnt_q == 4'd7) begin
              if (rxd_s2_q) begin
                rx_state_q <= S_IDLE;
              end else begin
                rx_cnt_q   <= 4'd0;
                rx_idx_q   <= 3'd0;
                rx_state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_cnt_q == 4'd15) begin
              rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
              rx_idx_q   <= rx_idx_q + 3'd1;
              if (rx_idx_q == 3'd7) rx_state_q <= par_q[0] ? S_PAR : S_STOP;
            end
          end
          S_PAR: begin
            if (rx_cnt_q == 4'd15) rx_state_q <= S_STOP;
          end
          default: begin
            if (rx_cnt_q == 4'd15) rx_state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  logic [31:0] prdata;
  always_comb begin
    prdata = 32'h0;
    if (hit) begin
      case (off)
        OFF_DATA:   prdata = {24'h0, rx_buf_q};
        OFF_STATUS: prdata = {27'h0, par_err_q, rx_ovr_q, tx_ovr_q, rx_full_q, tx_full_q};
        OFF_CTRL:   prdata = {25'h0, ctrl_q};
        OFF_INT:    prdata = {27'h0, int_q};
        OFF_BAUD:   prdata = {13'h0, baud_div_q};
        OFF_PAR:    prdata = {30'h0, par_q};
        default:    prdata = {28'h0, ECOREVNUM};
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  assign TXD          = txd_q;
  assign TXEN         = txen_q;
  assign BAUDTICK     = tick_q;
  assign TXINT        = int_q[0] & ctrl_q[2];
  assign RXINT        = int_q[1] & ctrl_q[3];
  assign TXOVRINT     = int_q[2] & ctrl_q[4];
  assign RXOVRINT     = int_q[3] & ctrl_q[5];
  assign UARTINT      = TXINT | RXINT | TXOVRINT | RXOVRINT;
  assign UARTINT_FLAG = |int_q;

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for a cross-connected pair of apb_uart instances on one APB bus.
// Expected values are hand-computed constants; every comparison goes through chk.
module tb_apb_uart;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic       PRESETn;
  logic [3:0] eco;
  logic       inject, inj_rxd;

  apb_uart_if bus_a();
  apb_uart_if bus_b();

  logic txd_a, txen_a, tick_a, txint_a, rxint_a, txovr_a, rxovr_a, flag_a, uint_a;
  logic txd_b, txen_b, tick_b, txint_b, rxint_b, txovr_b, rxovr_b, flag_b, uint_b;
  logic rxd_b;
  assign rxd_b = inject ? inj_rxd : txd_a;

  apb_uart #(.ADDR_SEL(1'b0)) u_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PCLKG(PCLK), .clk_16m(PCLK), .clk_16m_rstn(PRESETn),
    .apb(bus_a), .ECOREVNUM(eco), .RXD(txd_b), .TXD(txd_a), .TXEN(txen_a), .BAUDTICK(tick_a),
    .TXINT(txint_a), .RXINT(rxint_a), .TXOVRINT(txovr_a), .RXOVRINT(rxovr_a),
    .UARTINT_FLAG(flag_a), .UARTINT(uint_a)
  );

  apb_uart #(.ADDR_SEL(1'b1)) u_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PCLKG(PCLK), .clk_16m(PCLK), .clk_16m_rstn(PRESETn),
    .apb(bus_b), .ECOREVNUM(eco), .RXD(rxd_b), .TXD(txd_b), .TXEN(txen_b), .BAUDTICK(tick_b),
    .TXINT(txint_b), .RXINT(rxint_b), .TXOVRINT(txovr_b), .RXOVRINT(rxovr_b),
    .UARTINT_FLAG(flag_b), .UARTINT(uint_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_drive(input logic sel, input logic en, input logic wr,
                           input logic [9:0] addr, input logic [31:0] data);
    bus_a.PSEL = sel; bus_a.PENABLE = en; bus_a.PWRITE = wr; bus_a.PADDR = addr; bus_a.PWDATA = data;
    bus_b.PSEL = sel; bus_b.PENABLE = en; bus_b.PWRITE = wr; bus_b.PADDR = addr; bus_b.PWDATA = data;
  endtask

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    bus_drive(1'b1, 1'b0, 1'b1, addr, data);
    @(posedge PCLK); #1;
    bus_drive(1'b1, 1'b1, 1'b1, addr, data);
    @(posedge PCLK); #1;
    bus_drive(1'b0, 1'b0, 1'b0, addr, 32'h0);
    $display("apb wr addr=%03h data=%08h", addr, data);
  endtask

  task automatic apb_read(input logic [9:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    bus_drive(1'b1, 1'b0, 1'b0, addr, 32'h0);
    @(posedge PCLK); #1;
    bus_drive(1'b1, 1'b1, 1'b0, addr, 32'h0);
    #1;
    data = bus_a.PRDATA | bus_b.PRDATA;
    @(posedge PCLK); #1;
    bus_drive(1'b0, 1'b0, 1'b0, addr, 32'h0);
    $display("apb rd addr=%03h data=%08h", addr, data);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    chk(tag, d, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    logic        txen_seen;
    logic [10:0] inj_bits;
    int          ticks;

    PRESETn = 1'b0;
    eco     = 4'h0;
    inject  = 1'b0;
    inj_rxd = 1'b1;
    bus_drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_txd", {txd_a, txd_b}, 2'b11);
    chk("rst_txen", {txen_a, txen_b}, 2'b00);
    chk("rst_tick", {tick_a, tick_b}, 2'b00);
    chk("rst_ints", {uint_a, uint_b, flag_a, flag_b}, 4'h0);
    chk("rst_pready", {bus_a.PREADY, bus_b.PREADY}, 2'b11);
    chk("rst_pslverr", {bus_a.PSLVERR, bus_b.PSLVERR}, 2'b00);
    chk("rst_prdata", bus_a.PRDATA | bus_b.PRDATA, 32'h0);
    PRESETn = 1'b1;

    for (int i = 0; i < 16; i++) rd_chk("rst_read", 10'(i), 32'h0);

    // Configure both instances; B sits at word offset +8.
    for (int k = 0; k < 2; k++) begin
      apb_write(10'(8*k + 2), 32'h3F);
      apb_write(10'(8*k + 4), 32'h10);
      apb_write(10'(8*k + 5), 32'h01);
    end
    rd_chk("a_ctrl", 10'h002, 32'h3F);
    rd_chk("a_baud", 10'h004, 32'h10);
    rd_chk("a_par",  10'h005, 32'h01);
    rd_chk("b_ctrl", 10'h00A, 32'h3F);
    rd_chk("b_baud", 10'h00C, 32'h10);
    rd_chk("b_par",  10'h00D, 32'h01);

    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge PCLK); #1;
      if (tick_a && tick_b) ticks++;
    end
    chk("tick_every_cycle", ticks, 8);

    // A sends 0x34 while B sends 0xCD; A's line is sampled at each bit centre.
    fork
      begin
        for (int i = 0; i < 60 && txd_a; i++) begin
          @(posedge PCLK); #1;
        end
        repeat (8) @(posedge PCLK);
        #1;
        txen_seen = txen_a;
        for (int b = 0; b < 11; b++) begin
          frame[b] = txd_a;
          repeat (16) @(posedge PCLK);
          #1;
        end
      end
      begin
        apb_write(10'h000, 32'h34);
        apb_write(10'h008, 32'hCD);
      end
    join
    chk("a_tx_frame", frame, 11'h668);
    chk("a_txen_frame", txen_seen, 1'b1);
    chk("a_txen_end", txen_a, 1'b0);

    for (int i = 0; i < 400 && !(rxint_a && rxint_b); i++) begin
      @(posedge PCLK); #1;
    end
    chk("b_rxint", rxint_b, 1'b1);
    chk("a_rxint", rxint_a, 1'b1);
    for (int i = 0; i < 100 && (txen_a || txen_b); i++) begin
      @(posedge PCLK); #1;
    end
    rd_chk("b_status_full", 10'h009, 32'h02);
    rd_chk("b_intstatus", 10'h00B, 32'h03);
    rd_chk("a_intstatus", 10'h003, 32'h03);
    rd_chk("b_data", 10'h008, 32'h34);
    rd_chk("b_status_clr", 10'h009, 32'h00);
    rd_chk("a_data", 10'h000, 32'hCD);
    chk("uartint_both", {uint_a, uint_b}, 2'b11);
    apb_write(10'h003, 32'h1F);
    apb_write(10'h00B, 32'h1F);
    chk("uartint_w1c", {uint_a, uint_b, flag_a, flag_b}, 4'h0);

    // Overrun: first byte goes straight to the shifter, second fills the buffer.
    apb_write(10'h000, 32'h11);
    repeat (2) @(posedge PCLK);
    apb_write(10'h000, 32'h22);
    apb_write(10'h000, 32'h33);
    chk("a_txovrint", txovr_a, 1'b1);
    rd_chk("a_status_ovr", 10'h001, 32'h05);
    repeat (450) @(posedge PCLK);
    #1;
    rd_chk("a_status_done", 10'h001, 32'h04);
    rd_chk("b_status_rxovr", 10'h009, 32'h0A);
    chk("b_rxovrint", rxovr_b, 1'b1);
    rd_chk("b_data_kept", 10'h008, 32'h11);
    apb_write(10'h001, 32'h1C);
    apb_write(10'h009, 32'h1C);
    apb_write(10'h003, 32'h1F);
    apb_write(10'h00B, 32'h1F);
    rd_chk("b_status_w1c", 10'h009, 32'h00);
    chk("flags_clear", {flag_a, flag_b}, 2'b00);

    // 0x5A has even weight, so the correct even parity bit is 0; send 1 instead.
    inj_bits = {1'b1, 1'b1, 8'h5A, 1'b0};
    inj_rxd  = 1'b1;
    inject   = 1'b1;
    repeat (4) @(posedge PCLK);
    for (int b = 0; b < 11; b++) begin
      #1;
      inj_rxd = inj_bits[b];
      repeat (16) @(posedge PCLK);
    end
    repeat (20) @(posedge PCLK);
    #1;
    inject = 1'b0;
    rd_chk("b_status_par", 10'h009, 32'h12);
    chk("b_flag_par", flag_b, 1'b1);
    chk("b_rxint_par", rxint_b, 1'b1);
    rd_chk("b_int_par", 10'h00B, 32'h12);
    rd_chk("b_data_par", 10'h008, 32'h5A);

    eco = 4'hA;
    rd_chk("a_eco", 10'h006, 32'hA);
    rd_chk("b_eco", 10'h00F, 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
